// File: rtl/act_buf_pkg.sv
// Shared types and defaults for the ping-pong activation buffer.
// Bank lifecycle: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
package act_buf_pkg;

  localparam int DEF_DWIDTH = 8;
  localparam int DEF_AWIDTH = 14;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_t;

endpackage

// File: rtl/act_bank_fsm.sv
// Lifecycle tracker for one activation bank. The controller raises at most one
// meaningful request per bank per cycle; full wins over start so an empty frame can be synced.
module act_bank_fsm
  import act_buf_pkg::*;
(
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        start,
  input  logic        full,
  input  logic        take,
  input  logic        release_bank,
  output bank_state_t state
);

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state <= BANK_EMPTY;
    end else begin
      unique case (state)
        BANK_EMPTY: begin
          if (full)       state <= BANK_FULL;
          else if (start) state <= BANK_FILLING;
        end
        BANK_FILLING:  if (full)         state <= BANK_FULL;
        BANK_FULL:     if (take)         state <= BANK_DRAINING;
        BANK_DRAINING: if (release_bank) state <= BANK_EMPTY;
        default:                         state <= BANK_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/act_pingpong_ctrl.sv
// Ping-pong controller: routes the WriteAct port to bank[wp] and the PE read port
// to bank[rp], and runs the writer/PE frame handshakes between them.
module act_pingpong_ctrl
  import act_buf_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int AWIDTH = DEF_AWIDTH
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic [AWIDTH-1:0] wr_address,
  input  logic              wr_ce,
  input  logic              wr_we,
  input  logic [DWIDTH-1:0] wr_d,
  input  logic              wr_sync_vld,
  output logic              wr_sync_ack,
  output logic              wr_ready,
  input  logic [AWIDTH-1:0] rd_address,
  input  logic              rd_ce,
  output logic [DWIDTH-1:0] rd_q,
  output logic              pe_sync_vld,
  input  logic              pe_sync_ack,
  input  logic              pe_done,
  output logic [AWIDTH-1:0] b0_addr0,
  output logic              b0_ce0,
  input  logic [DWIDTH-1:0] b0_q0,
  output logic [AWIDTH-1:0] b0_addr1,
  output logic              b0_ce1,
  output logic              b0_we1,
  output logic [DWIDTH-1:0] b0_d1,
  output logic [AWIDTH-1:0] b1_addr0,
  output logic              b1_ce0,
  input  logic [DWIDTH-1:0] b1_q0,
  output logic [AWIDTH-1:0] b1_addr1,
  output logic              b1_ce1,
  output logic              b1_we1,
  output logic [DWIDTH-1:0] b1_d1,
  output logic [15:0]       frame_cnt
);

  bank_state_t st0, st1, wr_state, rd_state;
  logic        wp, rp, ack_q, rd_sel, wr_overrun;
  logic [15:0] cnt_q;
  logic        wr_gate, start_ev, take_ev, rel_ev;

  assign wr_state = wp ? st1 : st0;
  assign rd_state = rp ? st1 : st0;

  assign wr_ready    = (wr_state == BANK_EMPTY) || (wr_state == BANK_FILLING);
  assign wr_gate     = wr_ce & wr_ready;
  assign start_ev    = wr_ce & (wr_state == BANK_EMPTY);
  assign pe_sync_vld = (rd_state == BANK_FULL);
  assign take_ev     = pe_sync_ack & pe_sync_vld;
  assign rel_ev      = pe_done & (rd_state == BANK_DRAINING);
  assign wr_sync_ack = ack_q;
  assign frame_cnt   = cnt_q;
  assign rd_q        = rd_sel ? b1_q0 : b0_q0;

  // The bank is marked FULL during the ack cycle itself, so pe_sync_vld follows one cycle later.
  act_bank_fsm u_bank0 (
    .ap_clk       (ap_clk),
    .ap_rst       (ap_rst),
    .start        (start_ev & ~wp),
    .full         (ack_q & ~wp),
    .take         (take_ev & ~rp),
    .release_bank (rel_ev & ~rp),
    .state        (st0)
  );

  act_bank_fsm u_bank1 (
    .ap_clk       (ap_clk),
    .ap_rst       (ap_rst),
    .start        (start_ev & wp),
    .full         (ack_q & wp),
    .take         (take_ev & rp),
    .release_bank (rel_ev & rp),
    .state        (st1)
  );

  always_comb begin
    b0_addr0 = rp ? '0 : rd_address;
    b0_ce0   = rd_ce & ~rp;
    b1_addr0 = rp ? rd_address : '0;
    b1_ce0   = rd_ce & rp;
    b0_addr1 = wp ? '0 : wr_address;
    b0_ce1   = wr_gate & ~wp;
    b0_we1   = wr_gate & wr_we & ~wp;
    b0_d1    = wp ? '0 : wr_d;
    b1_addr1 = wp ? wr_address : '0;
    b1_ce1   = wr_gate & wp;
    b1_we1   = wr_gate & wr_we & wp;
    b1_d1    = wp ? wr_d : '0;
  end

  // ack_q blocks a second ack while the writer is still holding vld in the ack cycle.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      wp         <= 1'b0;
      rp         <= 1'b0;
      ack_q      <= 1'b0;
      rd_sel     <= 1'b0;
      cnt_q      <= 16'd0;
      wr_overrun <= 1'b0;
    end else begin
      ack_q      <= wr_sync_vld & ~ack_q & wr_ready;
      rd_sel     <= rp;
      wr_overrun <= wr_overrun | (wr_ce & ~wr_ready);
      if (ack_q) wp <= ~wp;
      if (rel_ev) begin
        rp    <= ~rp;
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_act_pingpong_ctrl.sv
// Bench for act_pingpong_ctrl: vector table, directed handover sequences and a
// randomized run against a frame-level reference model, with two BRAM banks modelled here.
module tb_act_pingpong_ctrl;
  localparam int DW = 8;
  localparam int AW = 14;
  localparam int EMP = 0, FIL = 1, FUL = 2, DRN = 3;

  logic          ap_clk = 1'b0;
  logic          ap_rst;
  logic [AW-1:0] wr_address, rd_address;
  logic          wr_ce, wr_we, wr_sync_vld, wr_sync_ack, wr_ready;
  logic [DW-1:0] wr_d, rd_q;
  logic          rd_ce, pe_sync_vld, pe_sync_ack, pe_done;
  logic [AW-1:0] b0_addr0, b0_addr1, b1_addr0, b1_addr1;
  logic          b0_ce0, b0_ce1, b0_we1, b1_ce0, b1_ce1, b1_we1;
  logic [DW-1:0] b0_q0, b0_d1, b1_q0, b1_d1;
  logic [15:0]   frame_cnt;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem0 [0:16383];
  logic [DW-1:0] mem1 [0:16383];

  act_pingpong_ctrl #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .wr_address(wr_address), .wr_ce(wr_ce), .wr_we(wr_we), .wr_d(wr_d),
    .wr_sync_vld(wr_sync_vld), .wr_sync_ack(wr_sync_ack), .wr_ready(wr_ready),
    .rd_address(rd_address), .rd_ce(rd_ce), .rd_q(rd_q),
    .pe_sync_vld(pe_sync_vld), .pe_sync_ack(pe_sync_ack), .pe_done(pe_done),
    .b0_addr0(b0_addr0), .b0_ce0(b0_ce0), .b0_q0(b0_q0),
    .b0_addr1(b0_addr1), .b0_ce1(b0_ce1), .b0_we1(b0_we1), .b0_d1(b0_d1),
    .b1_addr0(b1_addr0), .b1_ce0(b1_ce0), .b1_q0(b1_q0),
    .b1_addr1(b1_addr1), .b1_ce1(b1_ce1), .b1_we1(b1_we1), .b1_d1(b1_d1),
    .frame_cnt(frame_cnt)
  );

  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk) begin
    if (b0_ce1 && b0_we1) mem0[b0_addr1] <= b0_d1;
    if (b0_ce0) b0_q0 <= mem0[b0_addr0];
    if (b1_ce1 && b1_we1) mem1[b1_addr1] <= b1_d1;
    if (b1_ce0) b1_q0 <= mem1[b1_addr0];
  end

  typedef struct {
    logic [3:0]  in_bits;   // {wr_ce, wr_sync_vld, pe_sync_ack, pe_done}
    logic [2:0]  ex_flags;  // {wr_ready, wr_sync_ack, pe_sync_vld}
    logic [15:0] ex_cnt;
    logic [1:0]  ex_wsel;   // {b1_ce1, b0_ce1}
    logic [1:0]  ex_rsel;   // {b1_ce0, b0_ce0}
  } vec_t;
  vec_t vecs [13];

  // Reference model state: bank lifecycles, pointers and a shadow of addresses 0..15.
  int          m_st [2];
  bit          m_wp, m_rp, m_ack, m_ovr, exp_q_vld;
  logic [15:0] m_cnt;
  logic [DW-1:0] shadow [2][16];
  logic [DW-1:0] exp_q;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic set_idle();
    wr_address = '0; wr_ce = 1'b0; wr_we = 1'b0; wr_d = '0; wr_sync_vld = 1'b0;
    rd_address = '0; rd_ce = 1'b0; pe_sync_ack = 1'b0; pe_done = 1'b0;
  endtask

  task automatic reset_dut();
    set_idle();
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    #1;
  endtask

  task automatic write_frame(input logic [DW-1:0] off);
    for (int i = 0; i < 16; i++) begin
      wr_ce = 1'b1; wr_we = 1'b1; wr_address = AW'(i); wr_d = off + DW'(i);
      tick();
    end
    wr_ce = 1'b0; wr_we = 1'b0;
  endtask

  task automatic sync_frame(input logic exp_pvld, input string tag);
    wr_sync_vld = 1'b1;
    #1 check_output({tag, "_ack_early"}, 32'(wr_sync_ack), 32'd0);
    tick();
    check_output({tag, "_ack"}, 32'(wr_sync_ack), 32'd1);
    tick();
    wr_sync_vld = 1'b0;
    #1 check_output({tag, "_pvld"}, 32'(pe_sync_vld), 32'(exp_pvld));
    check_output({tag, "_ack_once"}, 32'(wr_sync_ack), 32'd0);
  endtask

  task automatic model_reset();
    m_st[0] = EMP; m_st[1] = EMP;
    m_wp = 1'b0; m_rp = 1'b0; m_ack = 1'b0; m_ovr = 1'b0; m_cnt = 16'd0;
  endtask

  // Advance the frame-level model by one clock using the inputs applied this cycle.
  task automatic model_step();
    int  nst [2];
    bit  ready, nwp, nrp;
    ready = (m_st[m_wp] == EMP) || (m_st[m_wp] == FIL);
    exp_q_vld = rd_ce && !ap_rst;
    if (rd_ce) exp_q = shadow[m_rp][rd_address[3:0]];
    if (wr_ce && wr_we && ready) shadow[m_wp][wr_address[3:0]] = wr_d;
    if (ap_rst) begin
      model_reset();
    end else begin
      nst = m_st; nwp = m_wp; nrp = m_rp;
      if (m_ack) begin
        nst[m_wp] = FUL;
        nwp = !m_wp;
      end else if (wr_ce && m_st[m_wp] == EMP) begin
        nst[m_wp] = FIL;
      end
      if (pe_sync_ack && m_st[m_rp] == FUL) nst[m_rp] = DRN;
      if (pe_done && m_st[m_rp] == DRN) begin
        nst[m_rp] = EMP;
        nrp = !m_rp;
        m_cnt = m_cnt + 16'd1;
      end
      m_ovr = m_ovr || (wr_ce && !ready);
      m_ack = wr_sync_vld && !m_ack && ready;
      m_st = nst; m_wp = nwp; m_rp = nrp;
    end
  endtask

  task automatic apply_stimulus(input int i);
    {wr_ce, wr_sync_vld, pe_sync_ack, pe_done} = vecs[i].in_bits;
    wr_we = wr_ce; wr_address = AW'(i); wr_d = DW'(i);
    rd_ce = 1'b1; rd_address = '0;
  endtask

  initial begin
    bit last_ack;
    vecs = '{
      '{4'b1000, 3'b100, 16'd0, 2'b01, 2'b01},
      '{4'b0100, 3'b100, 16'd0, 2'b00, 2'b01},
      '{4'b0100, 3'b110, 16'd0, 2'b00, 2'b01},
      '{4'b0001, 3'b101, 16'd0, 2'b00, 2'b01},
      '{4'b0010, 3'b101, 16'd0, 2'b00, 2'b01},
      '{4'b1000, 3'b100, 16'd0, 2'b10, 2'b01},
      '{4'b0100, 3'b100, 16'd0, 2'b00, 2'b01},
      '{4'b0101, 3'b110, 16'd0, 2'b00, 2'b01},
      '{4'b0000, 3'b101, 16'd1, 2'b00, 2'b10},
      '{4'b0010, 3'b101, 16'd1, 2'b00, 2'b10},
      '{4'b0010, 3'b100, 16'd1, 2'b00, 2'b10},
      '{4'b0001, 3'b100, 16'd1, 2'b00, 2'b10},
      '{4'b0000, 3'b100, 16'd2, 2'b00, 2'b01}
    };
    set_idle();
    ap_rst = 1'b1;
    tick(); tick();
    ap_rst = 1'b0;
    #1;
    check_output("rst_ready", 32'(wr_ready), 32'd1);
    check_output("rst_ack", 32'(wr_sync_ack), 32'd0);
    check_output("rst_pvld", 32'(pe_sync_vld), 32'd0);
    check_output("rst_cnt", 32'(frame_cnt), 32'd0);
    check_output("rst_ports", 32'({b0_ce0, b0_ce1, b0_we1, b1_ce0, b1_ce1, b1_we1}), 32'd0);

    for (int i = 0; i < 13; i++) begin
      apply_stimulus(i);
      #1;
      check_output($sformatf("vec%0d_ready", i), 32'(wr_ready), 32'(vecs[i].ex_flags[2]));
      check_output($sformatf("vec%0d_ack", i), 32'(wr_sync_ack), 32'(vecs[i].ex_flags[1]));
      check_output($sformatf("vec%0d_pvld", i), 32'(pe_sync_vld), 32'(vecs[i].ex_flags[0]));
      check_output($sformatf("vec%0d_cnt", i), 32'(frame_cnt), 32'(vecs[i].ex_cnt));
      check_output($sformatf("vec%0d_wsel", i), 32'({b1_ce1, b0_ce1}), 32'(vecs[i].ex_wsel));
      check_output($sformatf("vec%0d_rsel", i), 32'({b1_ce0, b0_ce0}), 32'(vecs[i].ex_rsel));
      tick();
    end

    // Single frame into bank0, then PE read of address 5.
    reset_dut();
    write_frame(8'h00);
    sync_frame(1'b1, "sf");
    pe_sync_ack = 1'b1;
    tick();
    pe_sync_ack = 1'b0;
    #1 check_output("sf_drain_pvld", 32'(pe_sync_vld), 32'd0);
    rd_ce = 1'b1; rd_address = AW'(5);
    tick();
    rd_ce = 1'b0;
    #1 check_output("sf_rd_q", 32'(rd_q), 32'h05);

    // Writer fills bank1 while the PE still drains bank0.
    write_frame(8'h40);
    sync_frame(1'b0, "ov");
    pe_done = 1'b1;
    tick();
    pe_done = 1'b0;
    #1 check_output("ov_cnt", 32'(frame_cnt), 32'd1);
    check_output("ov_rp", 32'(dut.rp), 32'd1);
    check_output("ov_pvld", 32'(pe_sync_vld), 32'd1);
    rd_ce = 1'b1; rd_address = AW'(2);
    tick();
    rd_ce = 1'b0;
    #1 check_output("ov_rd_q", 32'(rd_q), 32'h42);

    // Both banks full: third frame must wait, stray write is dropped.
    write_frame(8'h80);
    sync_frame(1'b1, "bp");
    check_output("bp_ready_low", 32'(wr_ready), 32'd0);
    wr_ce = 1'b1; wr_we = 1'b1; wr_address = AW'(3); wr_d = 8'hEE;
    #1 check_output("bp_ce_gated", 32'({b1_ce1, b0_ce1}), 32'd0);
    tick();
    wr_ce = 1'b0; wr_we = 1'b0;
    #1 check_output("bp_overrun", 32'(dut.wr_overrun), 32'd1);
    wr_sync_vld = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 check_output($sformatf("bp_hold%0d", k), 32'(wr_sync_ack), 32'd0);
      tick();
    end
    pe_sync_ack = 1'b1;
    tick();
    pe_sync_ack = 1'b0; pe_done = 1'b1;
    #1 check_output("bp_ack_drain", 32'(wr_sync_ack), 32'd0);
    tick();
    pe_done = 1'b0;
    #1 check_output("bp_ready_back", 32'(wr_ready), 32'd1);
    check_output("bp_ack_wait", 32'(wr_sync_ack), 32'd0);
    tick();
    check_output("bp_ack", 32'(wr_sync_ack), 32'd1);
    tick();
    wr_sync_vld = 1'b0;
    #1 check_output("bp_no_overwrite", 32'(mem1[3]), 32'h43);
    check_output("bp_cnt", 32'(frame_cnt), 32'd2);

    // Reset while bank0 is FILLING and bank1 is DRAINING.
    pe_sync_ack = 1'b1;
    tick();
    pe_sync_ack = 1'b0; pe_done = 1'b1;
    tick();
    pe_done = 1'b0; wr_ce = 1'b1; wr_we = 1'b1; wr_address = '0; wr_d = 8'h11;
    tick();
    wr_ce = 1'b0; wr_we = 1'b0; pe_sync_ack = 1'b1;
    tick();
    pe_sync_ack = 1'b0;
    #1 check_output("pre_rst_cnt", 32'(frame_cnt), 32'd3);
    check_output("pre_rst_rp", 32'(dut.rp), 32'd1);
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    #1 check_output("mid_rst_cnt", 32'(frame_cnt), 32'd0);
    check_output("mid_rst_pvld", 32'(pe_sync_vld), 32'd0);
    check_output("mid_rst_ready", 32'(wr_ready), 32'd1);
    check_output("mid_rst_ack", 32'(wr_sync_ack), 32'd0);
    check_output("mid_rst_wp", 32'(dut.wp), 32'd0);
    check_output("mid_rst_rp", 32'(dut.rp), 32'd0);
    pe_done = 1'b1;
    tick();
    pe_done = 1'b0;
    #1 check_output("mid_rst_no_drain", 32'(frame_cnt), 32'd0);

    // Randomized traffic against the reference model.
    reset_dut();
    model_reset();
    for (int i = 0; i < 16; i++) begin
      shadow[0][i] = mem0[i];
      shadow[1][i] = mem1[i];
    end
    exp_q_vld = 1'b0;
    last_ack = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      ap_rst = ($urandom_range(0, 399) == 0);
      if (last_ack) wr_sync_vld = 1'b0;
      else if (!wr_sync_vld && $urandom_range(0, 7) == 0) wr_sync_vld = 1'b1;
      wr_ce = ($urandom_range(0, 2) != 0);
      wr_we = ($urandom_range(0, 3) != 0);
      wr_address = AW'($urandom_range(0, 15));
      wr_d = DW'($urandom);
      pe_sync_ack = ($urandom_range(0, 3) == 0);
      pe_done = ($urandom_range(0, 5) == 0);
      rd_ce = ($urandom_range(0, 1) == 1);
      rd_address = AW'($urandom_range(0, 15));
      #1;
      check_output("rnd_ready", 32'(wr_ready), 32'((m_st[m_wp] == EMP) || (m_st[m_wp] == FIL)));
      check_output("rnd_ack", 32'(wr_sync_ack), 32'(m_ack));
      check_output("rnd_pvld", 32'(pe_sync_vld), 32'(m_st[m_rp] == FUL));
      check_output("rnd_cnt", 32'(frame_cnt), 32'(m_cnt));
      if (exp_q_vld) check_output("rnd_rd_q", 32'(rd_q), 32'(exp_q));
      last_ack = wr_sync_ack;
      model_step();
      tick();
    end
    set_idle();
    ap_rst = 1'b0;
    #1 check_output("rnd_overrun", 32'(dut.wr_overrun), 32'(m_ovr));

    $display("[TB] run complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
